// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: op encodings, default widths, execution-unit FSM states.
package cpu_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int CPU_AW    = 3;

  typedef logic [1:0] op_t;
  localparam op_t OP_MUL   = 2'b00;
  localparam op_t OP_MULHU = 2'b01;
  localparam op_t OP_DIVU  = 2'b10;
  localparam op_t OP_REMU  = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_CALC = 2'd1;
  localparam state_t ST_WB   = 2'd2;

  function automatic logic op_is_div(input op_t o);
    return (o == OP_DIVU) || (o == OP_REMU);
  endfunction

  // High half of the {hi, lo} pair holds MULHU result and REMU remainder.
  function automatic logic op_is_hi(input op_t o);
    return (o == OP_MULHU) || (o == OP_REMU);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit writing the register file; 33-cycle start-to-writeback.
// No input handshake beyond busy: start is ignored while busy, flush aborts before WB.
module mul_div_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_WIDTH,
  parameter int AW    = CPU_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [AW-1:0]    dst,
  input  logic             flush,
  output logic             busy,
  output logic             wb_we,
  output logic [AW-1:0]    wb_wa,
  output logic [WIDTH-1:0] wb_wd
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  op_t              op_q;
  logic [AW-1:0]    dst_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH-1:0] nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   sub_diff;

  // Multiply: lo holds the multiplier and shifts out as the product fills in from the top.
  // Divide: lo holds the dividend and shifts in quotient bits; hi is the partial remainder.
  always_comb begin
    nxt_hi   = hi;
    nxt_lo   = lo;
    add_sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    rem_sh   = {hi, lo[WIDTH-1]};
    sub_diff = rem_sh - {1'b0, b_q};
    if (op_is_div(op_q)) begin
      if (!sub_diff[WIDTH]) begin
        nxt_hi = sub_diff[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      {nxt_hi, nxt_lo} = {add_sum, lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= OP_MUL;
      dst_q <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
      wb_we <= 1'b0;
      wb_wa <= '0;
      wb_wd <= '0;
    end else begin
      wb_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            op_q  <= op;
            dst_q <= dst;
            b_q   <= b;
            hi    <= '0;
            lo    <= a;
            count <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (flush) begin
            state <= ST_IDLE;
            count <= '0;
          end else begin
            hi <= nxt_hi;
            lo <= nxt_lo;
            if (count == LAST) begin
              count <= '0;
              state <= ST_WB;
              wb_we <= 1'b1;
              wb_wa <= dst_q;
              wb_wd <= op_is_hi(op_q) ? nxt_hi : nxt_lo;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        ST_WB:   state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: results, latency, flush, reset and ignored-start cases.
module tb_mul_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  dst;
  logic        flush;
  logic        busy;
  logic        wb_we;
  logic [2:0]  wb_wa;
  logic [31:0] wb_wd;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.WIDTH(32), .AW(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .dst   (dst),
    .flush (flush),
    .busy  (busy),
    .wb_we (wb_we),
    .wb_wa (wb_wa),
    .wb_wd (wb_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives start for one edge; on return the DUT is in cycle 1 of the operation.
  task automatic accept(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [2:0] d);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; dst = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full operation: checks busy/no-write through CALC, the WB cycle (33) and the IDLE cycle (34).
  // poke>0 re-strobes start with different operands in that cycle; flush_wb raises flush during WB.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [2:0] d, input logic [31:0] exp_wd,
                        input int poke, input bit flush_wb);
    int bad;
    bad = 0;
    accept(o, x, y, d);
    for (int c = 1; c <= 32; c++) begin
      @(negedge clk);
      if (wb_we !== 1'b0 || busy !== 1'b1) bad++;
      if (c == poke) begin
        start = 1'b1; op = ~o; a = ~x; b = y + 32'd3; dst = ~d;
      end
      @(posedge clk);
      #1 start = 1'b0;
    end
    check({tag, ".calc_phase_bad_cycles"}, bad, 0);
    @(negedge clk);
    check({tag, ".wb_we@33"}, {31'd0, wb_we}, 32'd1);
    check({tag, ".wb_wa@33"}, {29'd0, wb_wa}, {29'd0, d});
    check({tag, ".wb_wd@33"}, wb_wd, exp_wd);
    if (flush_wb) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check({tag, ".busy@34"}, {31'd0, busy}, 32'd0);
    check({tag, ".wb_we@34"}, {31'd0, wb_we}, 32'd0);
    check({tag, ".wb_wd_hold@34"}, wb_wd, exp_wd);
  endtask

  // Counts any write pulse over n cycles.
  task automatic no_write(input string tag, input int n);
    int seen;
    seen = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (wb_we !== 1'b0) seen++;
    end
    check({tag, ".wb_we_pulses"}, seen, 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; dst = '0; flush = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.busy",  {31'd0, busy},  32'd0);
    check("reset.wb_we", {31'd0, wb_we}, 32'd0);
    check("reset.wb_wa", {29'd0, wb_wa}, 32'd0);
    check("reset.wb_wd", wb_wd,          32'd0);
    rst = 1'b0;

    run_op("mul_7x6",     2'b00, 32'd7,        32'd6,        3'd3, 32'h0000_002A, 0, 1'b0);
    run_op("mulhu_max",   2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd1, 32'hFFFF_FFFE, 0, 1'b0);
    run_op("mul_max",     2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 32'h0000_0001, 0, 1'b0);
    run_op("mul_shift",   2'b00, 32'h1234_5678, 32'h10,       3'd4, 32'h2345_6780, 0, 1'b0);
    run_op("mulhu_shift", 2'b01, 32'h1234_5678, 32'h10,       3'd5, 32'h0000_0001, 0, 1'b0);
    run_op("divu_100_7",  2'b10, 32'd100,      32'd7,        3'd6, 32'h0000_000E, 0, 1'b0);
    run_op("remu_100_7",  2'b11, 32'd100,      32'd7,        3'd7, 32'h0000_0002, 0, 1'b0);
    run_op("divu_5_0",    2'b10, 32'd5,        32'd0,        3'd1, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("remu_5_0",    2'b11, 32'd5,        32'd0,        3'd2, 32'h0000_0005, 0, 1'b0);
    run_op("divu_max_1",  2'b10, 32'hFFFF_FFFF, 32'd1,        3'd3, 32'hFFFF_FFFF, 0, 1'b0);
    run_op("remu_hex",    2'b11, 32'h1234_5678, 32'h1000,     3'd4, 32'h0000_0678, 0, 1'b0);
    run_op("divu_small",  2'b10, 32'd3,        32'd9,        3'd5, 32'h0000_0000, 0, 1'b0);

    // Start pulsed mid-operation with different operands must be ignored.
    run_op("mul_poke5",   2'b00, 32'd7,        32'd6,        3'd3, 32'h0000_002A, 5, 1'b0);

    // Flush during WB does not cancel the write.
    run_op("flush_in_wb", 2'b11, 32'd100,      32'd7,        3'd6, 32'h0000_0002, 0, 1'b1);

    // Flush at cycle 10 of a DIVU.
    accept(2'b10, 32'd100, 32'd7, 3'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush10.busy@11",  {31'd0, busy},  32'd0);
    check("flush10.wa_hold",  {29'd0, wb_wa}, 32'd6);
    check("flush10.wd_hold",  wb_wd,          32'h0000_0002);
    no_write("flush10", 40);
    run_op("after_flush", 2'b10, 32'd1000, 32'd10, 3'd2, 32'd100, 0, 1'b0);

    // Reset at cycle 20 of a MUL.
    accept(2'b00, 32'd9, 32'd9, 3'd7);
    repeat (19) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst20.busy",  {31'd0, busy},  32'd0);
    check("rst20.wb_we", {31'd0, wb_we}, 32'd0);
    check("rst20.wb_wa", {29'd0, wb_wa}, 32'd0);
    check("rst20.wb_wd", wb_wd,          32'd0);
    no_write("rst20", 40);

    // Start and flush together in IDLE: flush wins.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4; dst = 3'd1;
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    check("start_flush.busy", {31'd0, busy}, 32'd0);
    no_write("start_flush", 40);
    check("start_flush.busy_end", {31'd0, busy}, 32'd0);

    run_op("final_mul", 2'b00, 32'd3, 32'd4, 3'd1, 32'd12, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
